// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the CPU's single memory port between the multicycle datapath
//   (port 0, "cpu") and a program loader / DMA engine (port 1, "dma").
//   Accesses are serialised through an IDLE -> ACCESS -> RESP FSM. The
//   winning request is captured on the arbitration edge. The owner then
//   sees a one-cycle grant in ACCESS and a one-cycle done in RESP, with
//   read data presented alongside done.
//
// Configuration macro:
//   ARB_CPU_PRIORITY_EN - when defined, port 0 always wins ties (port 1 can
//                         starve). When undefined, ties alternate round-robin.
//
// Ports:
//   clock_i                 sole clock, rising edge
//   reset_i                 synchronous, active-high reset
//   cpu_req_i / dma_req_i   access request (level)
//   cpu_we_i / dma_we_i     1 = store, 0 = load
//   cpu_addr_i / dma_addr_i word address of the access
//   cpu_wdata_i/dma_wdata_i store data
//   cpu_gnt_o / dma_gnt_o   one-cycle grant pulse (ACCESS cycle)
//   cpu_done_o / dma_done_o one-cycle completion pulse (RESP cycle)
//   cpu_rdata_o/dma_rdata_o read data, held until that port's next read
//   mem_en_o                memory access strobe (ACCESS cycle only)
//   mem_we_o                memory write enable
//   mem_addr_o              memory address
//   mem_wdata_o             memory write data
//   mem_rdata_i             memory read data, valid the cycle after mem_en_o
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic          cpu_done_o,
    output logic [DW-1:0] cpu_rdata_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic          dma_gnt_o,
    output logic          dma_done_o,
    output logic [DW-1:0] dma_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q;
    logic            sel_q;
    logic            last_grant_q;
    logic            cpu_gnt_q;
    logic            dma_gnt_q;
    logic            cpu_done_q;
    logic            dma_done_q;
    logic            mem_en_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [DW-1:0]   cpu_rdata_q;
    logic [DW-1:0]   dma_rdata_q;

    logic            any_req;
    logic            winner_d;
    logic            req_we_d;
    logic [AW-1:0]   req_addr_d;
    logic [DW-1:0]   req_wdata_d;

    // Pick the winner among the current requests and mux its access fields.
    // Port id 0 is the cpu, 1 is the dma engine.
    always_comb begin
        any_req = cpu_req_i | dma_req_i;
`ifdef ARB_CPU_PRIORITY_EN
        // The cpu wins whenever it asks; last_grant_q is tracked but unused.
        winner_d = ~cpu_req_i;
`else
        // On a tie, the port that did not win last time goes next.
        if (cpu_req_i && dma_req_i) begin
            winner_d = ~last_grant_q;
        end else begin
            winner_d = dma_req_i;
        end
`endif
        req_we_d    = winner_d ? dma_we_i    : cpu_we_i;
        req_addr_d  = winner_d ? dma_addr_i  : cpu_addr_i;
        req_wdata_d = winner_d ? dma_wdata_i : cpu_wdata_i;
    end

    // Main FSM with registered outputs. Pulses (gnt, done, mem_en) default
    // low every cycle and are raised only for the single cycle they belong
    // to. RESP both retires the current access and can launch the next one,
    // which gives one access every two cycles under back-to-back traffic.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_done_q   <= 1'b0;
            dma_done_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            cpu_gnt_q  <= 1'b0;
            dma_gnt_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            dma_done_q <= 1'b0;
            mem_en_q   <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    // The memory drives read data during RESP, so it is
                    // captured into the owner's holding register here.
                    if (state_q == RESP && !mem_we_q) begin
                        if (sel_q) begin
                            dma_rdata_q <= mem_rdata_i;
                        end else begin
                            cpu_rdata_q <= mem_rdata_i;
                        end
                    end
                    if (any_req) begin
                        state_q      <= ACCESS;
                        sel_q        <= winner_d;
                        last_grant_q <= winner_d;
                        mem_we_q     <= req_we_d;
                        mem_addr_q   <= req_addr_d;
                        mem_wdata_q  <= req_wdata_d;
                        mem_en_q     <= 1'b1;
                        cpu_gnt_q    <= ~winner_d;
                        dma_gnt_q    <= winner_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    state_q    <= RESP;
                    cpu_done_q <= ~sel_q;
                    dma_done_q <= sel_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // During a read's RESP cycle the memory's output is forwarded straight
    // through so data is visible together with done; afterwards the
    // captured copy holds it.
    always_comb begin
        cpu_rdata_o = (cpu_done_q && !mem_we_q) ? mem_rdata_i : cpu_rdata_q;
        dma_rdata_o = (dma_done_q && !mem_we_q) ? mem_rdata_i : dma_rdata_q;
    end

    assign cpu_gnt_o   = cpu_gnt_q;
    assign dma_gnt_o   = dma_gnt_q;
    assign cpu_done_o  = cpu_done_q;
    assign dma_done_o  = dma_done_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Self-checking bench for mem_port_arbiter. A small synchronous memory
//   model sits on the memory port. Directed stimulus pushes expected grants
//   and completions into queues. Monitor processes pop and compare them
//   whenever the DUT raises a grant or done. Inline checks cover cycle
//   timing, reset values and the tie-break order. Honours
//   ARB_CPU_PRIORITY_EN for the expected contention order.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } resp_t;

    logic        clock;
    logic        reset;
    logic        cpuReq, cpuWe, cpuGnt, cpuDone;
    logic [15:0] cpuAddr;
    logic [31:0] cpuWdata, cpuRdata;
    logic        dmaReq, dmaWe, dmaGnt, dmaDone;
    logic [15:0] dmaAddr;
    logic [31:0] dmaWdata, dmaRdata;
    logic        memEn, memWe;
    logic [15:0] memAddr;
    logic [31:0] memWdata, memRdata;

    logic [31:0] memArray [0:255];

    resp_t doneQ[$];
    logic  gntQ[$];

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.AW(16), .DW(32)) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .cpu_req_i  (cpuReq),
        .cpu_we_i   (cpuWe),
        .cpu_addr_i (cpuAddr),
        .cpu_wdata_i(cpuWdata),
        .cpu_gnt_o  (cpuGnt),
        .cpu_done_o (cpuDone),
        .cpu_rdata_o(cpuRdata),
        .dma_req_i  (dmaReq),
        .dma_we_i   (dmaWe),
        .dma_addr_i (dmaAddr),
        .dma_wdata_i(dmaWdata),
        .dma_gnt_o  (dmaGnt),
        .dma_done_o (dmaDone),
        .dma_rdata_o(dmaRdata),
        .mem_en_o   (memEn),
        .mem_we_o   (memWe),
        .mem_addr_o (memAddr),
        .mem_wdata_o(memWdata),
        .mem_rdata_i(memRdata)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model: synchronous array, read data appears the cycle after
    // the strobe, writes land on the strobed edge.
    initial begin
        for (int i = 0; i < 256; i++) begin
            memArray[i] = 32'h0;
        end
        memArray[8'h10] = 32'hDEADBEEF;
        memRdata = 32'h0;
    end

    always @(posedge clock) begin
        if (memEn) begin
            if (memWe) begin
                memArray[memAddr[7:0]] <= memWdata;
            end else begin
                memRdata <= memArray[memAddr[7:0]];
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison with bookkeeping.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Grant monitor: every grant must match the next expected owner, and
    // the two grants may never be high together.
    always @(negedge clock) begin
        if (cpuGnt || dmaGnt) begin
            checkOutput("gntMutex", 32'(cpuGnt & dmaGnt), 32'h0);
            if (gntQ.size() == 0) begin
                checkOutput("gntUnexpected", 32'(dmaGnt), 32'hFFFFFFFF);
            end else begin
                checkOutput("gntPort", 32'(dmaGnt), 32'(gntQ.pop_front()));
            end
        end
    end

    // Completion monitor: every done must match the next expected port and
    // read data.
    always @(negedge clock) begin
        if (cpuDone || dmaDone) begin
            resp_t e;
            checkOutput("doneMutex", 32'(cpuDone & dmaDone), 32'h0);
            if (doneQ.size() == 0) begin
                checkOutput("doneUnexpected", 32'(dmaDone), 32'hFFFFFFFF);
            end else begin
                e = doneQ.pop_front();
                checkOutput("donePort", 32'(dmaDone), 32'(e.port));
                checkOutput("doneRdata", dmaDone ? dmaRdata : cpuRdata, e.rdata);
            end
        end
    end

    // One isolated access on a port, starting from IDLE; the FSM is back in
    // IDLE when the task returns.
    task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata);
        resp_t r;
        r.port  = port;
        r.rdata = expRdata;
        doneQ.push_back(r);
        gntQ.push_back(port);
        if (port) begin
            dmaReq = 1'b1; dmaWe = we; dmaAddr = addr; dmaWdata = wdata;
        end else begin
            cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
        end
        @(posedge clock); #1;
        checkOutput("accGnt", 32'(port ? dmaGnt : cpuGnt), 32'h1);
        checkOutput("accOtherGnt", 32'(port ? cpuGnt : dmaGnt), 32'h0);
        checkOutput("accMemEn", 32'(memEn), 32'h1);
        checkOutput("accMemWe", 32'(memWe), 32'(we));
        checkOutput("accMemAddr", 32'(memAddr), 32'(addr));
        if (we) begin
            checkOutput("accMemWdata", memWdata, wdata);
        end
        cpuReq = 1'b0;
        dmaReq = 1'b0;
        @(posedge clock); #1;
        checkOutput("respDone", 32'(port ? dmaDone : cpuDone), 32'h1);
        checkOutput("respOtherDone", 32'(port ? cpuDone : dmaDone), 32'h0);
        checkOutput("respMemEn", 32'(memEn), 32'h0);
        @(posedge clock); #1;
        checkOutput("idleDone", 32'(cpuDone | dmaDone), 32'h0);
    endtask

    logic [8:1] expCpuG;
    logic [8:1] expDmaG;

    // Directed test sequence.
    initial begin
        resp_t r;
        reset = 1'b1;
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 16'h0; cpuWdata = 32'h0;
        dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = 16'h0; dmaWdata = 32'h0;
        repeat (2) @(posedge clock);
        #1;

        // Reset values.
        checkOutput("rstCpuGnt", 32'(cpuGnt), 32'h0);
        checkOutput("rstDmaGnt", 32'(dmaGnt), 32'h0);
        checkOutput("rstCpuDone", 32'(cpuDone), 32'h0);
        checkOutput("rstDmaDone", 32'(dmaDone), 32'h0);
        checkOutput("rstMemEn", 32'(memEn), 32'h0);
        checkOutput("rstMemWe", 32'(memWe), 32'h0);
        checkOutput("rstMemAddr", 32'(memAddr), 32'h0);
        checkOutput("rstMemWdata", memWdata, 32'h0);
        checkOutput("rstCpuRdata", cpuRdata, 32'h0);
        checkOutput("rstDmaRdata", dmaRdata, 32'h0);
        reset = 1'b0;

        // Single cpu read; dma side stays quiet.
        applyStimulus(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF);
        checkOutput("readDmaRdata", dmaRdata, 32'h0);
        checkOutput("readCpuHeld", cpuRdata, 32'hDEADBEEF);

        // dma write then read back; write leaves dma rdata at 0.
        applyStimulus(1'b1, 1'b1, 16'h0020, 32'h12345678, 32'h0);
        applyStimulus(1'b1, 1'b0, 16'h0020, 32'h0, 32'h12345678);
        checkOutput("wrRdDmaRdata", dmaRdata, 32'h12345678);
        checkOutput("wrRdCpuRdata", cpuRdata, 32'hDEADBEEF);

        // Late request: dma rises during the cpu ACCESS.
        gntQ.push_back(1'b0); gntQ.push_back(1'b1);
        r.port = 1'b0; r.rdata = 32'hDEADBEEF; doneQ.push_back(r);
        r.port = 1'b1; r.rdata = 32'h12345678; doneQ.push_back(r);
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0010;
        @(posedge clock); #1;
        checkOutput("lateCpuGnt", 32'(cpuGnt), 32'h1);
        cpuReq = 1'b0;
        dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0020;
        @(posedge clock); #1;
        checkOutput("lateRespDmaGnt", 32'(dmaGnt), 32'h0);
        @(posedge clock); #1;
        checkOutput("lateDmaGnt", 32'(dmaGnt), 32'h1);
        checkOutput("lateMemAddr", 32'(memAddr), 32'h20);
        dmaReq = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checkOutput("lateIdleMemEn", 32'(memEn), 32'h0);

        // Back-to-back cpu reads: req held through RESP.
        gntQ.push_back(1'b0); gntQ.push_back(1'b0);
        r.port = 1'b0; r.rdata = 32'hDEADBEEF; doneQ.push_back(r); doneQ.push_back(r);
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0010;
        @(posedge clock); #1;
        checkOutput("b2bGnt1", 32'(cpuGnt), 32'h1);
        @(posedge clock); #1;
        checkOutput("b2bRespMemEn", 32'(memEn), 32'h0);
        @(posedge clock); #1;
        checkOutput("b2bGnt2", 32'(cpuGnt), 32'h1);
        checkOutput("b2bMemEn2", 32'(memEn), 32'h1);
        cpuReq = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;

        // Contention straight after reset.
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("contRstCpuRdata", cpuRdata, 32'h0);
`ifdef ARB_CPU_PRIORITY_EN
        expCpuG = 8'b0101_0101;
        expDmaG = 8'b0000_0000;
        for (int i = 0; i < 4; i++) begin
            gntQ.push_back(1'b0);
            r.port = 1'b0; r.rdata = 32'hDEADBEEF; doneQ.push_back(r);
        end
`else
        expCpuG = 8'b0001_0001;
        expDmaG = 8'b0100_0100;
        for (int i = 0; i < 2; i++) begin
            gntQ.push_back(1'b0); gntQ.push_back(1'b1);
            r.port = 1'b0; r.rdata = 32'hDEADBEEF; doneQ.push_back(r);
            r.port = 1'b1; r.rdata = 32'h12345678; doneQ.push_back(r);
        end
`endif
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0010;
        dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0020;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            checkOutput("contCpuGnt", 32'(cpuGnt), 32'(expCpuG[k]));
            checkOutput("contDmaGnt", 32'(dmaGnt), 32'(expDmaG[k]));
            if (k == 8) begin
                cpuReq = 1'b0;
                dmaReq = 1'b0;
            end
        end
        @(posedge clock); #1;
        checkOutput("contIdleMemEn", 32'(memEn), 32'h0);

        // Reset during a dma read ACCESS: no done, everything cleared, and
        // the following tie goes to the cpu.
        gntQ.push_back(1'b1);
        dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0020;
        @(posedge clock); #1;
        checkOutput("abortDmaGnt", 32'(dmaGnt), 32'h1);
        reset = 1'b1;
        dmaReq = 1'b0;
        @(posedge clock); #1;
        checkOutput("abortDmaDone", 32'(dmaDone), 32'h0);
        checkOutput("abortCpuDone", 32'(cpuDone), 32'h0);
        checkOutput("abortMemEn", 32'(memEn), 32'h0);
        checkOutput("abortMemAddr", 32'(memAddr), 32'h0);
        checkOutput("abortCpuRdata", cpuRdata, 32'h0);
        checkOutput("abortDmaRdata", dmaRdata, 32'h0);
        reset = 1'b0;
        gntQ.push_back(1'b0);
        r.port = 1'b0; r.rdata = 32'hDEADBEEF; doneQ.push_back(r);
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0010;
        dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0020;
        @(posedge clock); #1;
        checkOutput("tieCpuGnt", 32'(cpuGnt), 32'h1);
        checkOutput("tieDmaGnt", 32'(dmaGnt), 32'h0);
        cpuReq = 1'b0;
        dmaReq = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;

        // Every expected grant and completion must have been seen.
        checkOutput("gntQEmpty", 32'(gntQ.size()), 32'h0);
        checkOutput("doneQEmpty", 32'(doneQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
